// File: rtl/usb_rx_pkt_decoder_if.sv
// -----------------------------------------------------------------------------
// usb_rx_pkt_decoder_if
// Bundles the UTMI receive stream and the decoded results of usb_rx_pkt_decoder.
//   rx_data/rx_valid/rx_active/rx_err : UTMI receive side (driven by PHY)
//   pid, pid_valid, pid_err           : PID result, held PID + 1-clk strobes
//   token_addr, token_ep, frame_no    : held token fields
//   token_valid, crc5_err             : 1-clk token completion strobes
//   data_out, data_valid              : payload byte stream (CRC bytes removed)
//   data_done, crc16_err, pkt_err     : 1-clk end-of-packet / error strobes
// Modport slave is the decoder; modport master is the PHY/protocol-engine side.
// -----------------------------------------------------------------------------
interface usb_rx_pkt_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_active;
    logic        rx_err;

    logic [3:0]  pid;
    logic        pid_valid;
    logic        pid_err;
    logic [6:0]  token_addr;
    logic [3:0]  token_ep;
    logic        token_valid;
    logic        crc5_err;
    logic [10:0] frame_no;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_done;
    logic        crc16_err;
    logic        pkt_err;

    modport slave (
        input  rx_data, rx_valid, rx_active, rx_err,
        output pid, pid_valid, pid_err, token_addr, token_ep, token_valid,
               crc5_err, frame_no, data_out, data_valid, data_done,
               crc16_err, pkt_err
    );

    modport master (
        output rx_data, rx_valid, rx_active, rx_err,
        input  pid, pid_valid, pid_err, token_addr, token_ep, token_valid,
               crc5_err, frame_no, data_out, data_valid, data_done,
               crc16_err, pkt_err
    );
endinterface

// File: rtl/usb_rx_pkt_decoder.sv
// -----------------------------------------------------------------------------
// usb_rx_pkt_decoder
// Disassembles USB packets from the UTMI receive byte stream: checks the PID,
// extracts token address/endpoint (or SOF frame number) with CRC5 check, and
// forwards data payload with the two CRC16 bytes stripped.
// Ports:
//   clk : system clock, same clock as the receive PHY
//   rst : asynchronous active-low reset
//   bus : usb_rx_pkt_decoder_if.slave (UTMI inputs, registered results)
// -----------------------------------------------------------------------------
module usb_rx_pkt_decoder (
    input  logic                clk,
    input  logic                rst,
    usb_rx_pkt_decoder_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHK, S_DRAIN} state_t;

    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [3:0]  PID_SOF        = 4'h5;

    // Serial CRCs unrolled over one byte, bit 0 first as on the wire.
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] din);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (din[i] ^ c[4]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (din[i] ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        return c;
    endfunction

    state_t      state_q, state_d;
    logic        rx_act_q;
    logic [1:0]  cnt_q, cnt_d, cnt_inc, end_cnt;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  dly0_q, dly0_d, dly1_q, dly1_d;
    logic [4:0]  crc5_q, crc5_d, crc5_nxt;
    logic [15:0] crc16_q, crc16_d, crc16_nxt, end_crc;
    logic        pid_valid_d, pid_err_d, token_valid_d, crc5_err_d;
    logic        data_valid_d, data_done_d, crc16_err_d, pkt_err_d;
    logic        pkt_start, pid_ok;

    assign pkt_start = bus.rx_active & ~rx_act_q;
    assign pid_ok    = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pkt_start) state_d = S_PID;
            S_PID: begin
                if (bus.rx_err) state_d = S_DRAIN;
                else if (bus.rx_valid) begin
                    if (!pid_ok) state_d = S_DRAIN;
                    else begin
                        case (bus.rx_data[1:0])
                            2'b01:   state_d = S_TOKEN;
                            2'b11:   state_d = S_DATA;
                            2'b10:   state_d = S_HSHK;
                            default: state_d = S_DRAIN;
                        endcase
                    end
                end
                else if (!bus.rx_active) state_d = S_IDLE;
            end
            S_TOKEN: begin
                if (bus.rx_err) state_d = S_DRAIN;
                else if (bus.rx_valid && cnt_q == 2'd2) state_d = bus.rx_active ? S_DRAIN : S_IDLE;
                else if (!bus.rx_active) state_d = S_IDLE;
            end
            S_DATA: begin
                if (bus.rx_err) state_d = S_DRAIN;
                else if (!bus.rx_active) state_d = S_IDLE;
            end
            S_HSHK: begin
                if (bus.rx_err) state_d = S_DRAIN;
                else if (bus.rx_valid) state_d = bus.rx_active ? S_DRAIN : S_IDLE;
                else if (!bus.rx_active) state_d = S_IDLE;
            end
            S_DRAIN: if (!bus.rx_active) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic. A byte arriving together with the rx_active
    // fall is folded into the end-of-packet decision in the same cycle.
    always_comb begin
        // NOTE: everything assigned here gets a default first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        pid_valid_d   = 1'b0;
        pid_err_d     = 1'b0;
        token_valid_d = 1'b0;
        crc5_err_d    = 1'b0;
        data_valid_d  = 1'b0;
        data_done_d   = 1'b0;
        crc16_err_d   = 1'b0;
        pkt_err_d     = 1'b0;
        cnt_d         = cnt_q;
        byte0_d       = byte0_q;
        dly0_d        = dly0_q;
        dly1_d        = dly1_q;
        crc5_d        = crc5_q;
        crc16_d       = crc16_q;
        crc5_nxt      = crc5_byte(crc5_q, bus.rx_data);
        crc16_nxt     = crc16_byte(crc16_q, bus.rx_data);
        cnt_inc       = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
        end_cnt       = bus.rx_valid ? cnt_inc : cnt_q;
        end_crc       = bus.rx_valid ? crc16_nxt : crc16_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = 2'd0;
                crc5_d  = CRC5_INIT;
                crc16_d = CRC16_INIT;
            end
            S_PID: begin
                if (bus.rx_err) pkt_err_d = 1'b1;
                else if (bus.rx_valid) begin
                    pid_valid_d = pid_ok;
                    pid_err_d   = ~pid_ok;
                end
            end
            S_TOKEN: begin
                if (bus.rx_err) pkt_err_d = 1'b1;
                else begin
                    if (bus.rx_valid) begin
                        case (cnt_q)
                            2'd0: begin
                                byte0_d = bus.rx_data;
                                crc5_d  = crc5_nxt;
                                cnt_d   = 2'd1;
                            end
                            2'd1: begin
                                crc5_d = crc5_nxt;
                                cnt_d  = 2'd2;
                                if (crc5_nxt == CRC5_RESIDUAL) token_valid_d = 1'b1;
                                else                           crc5_err_d    = 1'b1;
                            end
                            default: pkt_err_d = 1'b1;
                        endcase
                    end
                    if (!bus.rx_active && end_cnt != 2'd2) pkt_err_d = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.rx_err) pkt_err_d = 1'b1;
                else begin
                    if (bus.rx_valid) begin
                        // Two-byte delay line: the last two bytes are the CRC
                        // and are never shifted out.
                        crc16_d      = crc16_nxt;
                        dly0_d       = dly1_q;
                        dly1_d       = bus.rx_data;
                        cnt_d        = cnt_inc;
                        data_valid_d = (cnt_q == 2'd2);
                    end
                    if (!bus.rx_active) begin
                        if (end_cnt != 2'd2) begin
                            crc16_err_d = 1'b1;
                            pkt_err_d   = 1'b1;
                        end
                        else if (end_crc == CRC16_RESIDUAL) data_done_d = 1'b1;
                        else                                crc16_err_d = 1'b1;
                    end
                end
            end
            S_HSHK:  if (bus.rx_err || bus.rx_valid) pkt_err_d = 1'b1;
            S_DRAIN: if (bus.rx_err) pkt_err_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Reset high so a packet still in flight when reset lifts is not
            // mistaken for a new rx_active rise.
            rx_act_q        <= 1'b1;
            cnt_q           <= 2'd0;
            byte0_q         <= '0;
            dly0_q          <= '0;
            dly1_q          <= '0;
            crc5_q          <= CRC5_INIT;
            crc16_q         <= CRC16_INIT;
            bus.pid         <= '0;
            bus.pid_valid   <= 1'b0;
            bus.pid_err     <= 1'b0;
            bus.token_addr  <= '0;
            bus.token_ep    <= '0;
            bus.token_valid <= 1'b0;
            bus.crc5_err    <= 1'b0;
            bus.frame_no    <= '0;
            bus.data_out    <= '0;
            bus.data_valid  <= 1'b0;
            bus.data_done   <= 1'b0;
            bus.crc16_err   <= 1'b0;
            bus.pkt_err     <= 1'b0;
        end
        else begin
            rx_act_q        <= bus.rx_active;
            cnt_q           <= cnt_d;
            byte0_q         <= byte0_d;
            dly0_q          <= dly0_d;
            dly1_q          <= dly1_d;
            crc5_q          <= crc5_d;
            crc16_q         <= crc16_d;
            bus.pid_valid   <= pid_valid_d;
            bus.pid_err     <= pid_err_d;
            bus.token_valid <= token_valid_d;
            bus.crc5_err    <= crc5_err_d;
            bus.data_valid  <= data_valid_d;
            bus.data_done   <= data_done_d;
            bus.crc16_err   <= crc16_err_d;
            bus.pkt_err     <= pkt_err_d;
            if (pid_valid_d) bus.pid <= bus.rx_data[3:0];
            // Byte1 carries {crc5, field[10:8]}; byte0 carries field[7:0].
            if (token_valid_d) begin
                if (bus.pid == PID_SOF) bus.frame_no <= {bus.rx_data[2:0], byte0_q};
                else begin
                    bus.token_addr <= byte0_q[6:0];
                    bus.token_ep   <= {bus.rx_data[2:0], byte0_q[7]};
                end
            end
            if (data_valid_d) bus.data_out <= dly0_q;
        end
    end
endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_pkt_decoder
// Directed self-checking bench for usb_rx_pkt_decoder. Inputs change on the
// falling clock edge; a negedge monitor counts every output strobe and collects
// payload bytes. CRC bytes for generated packets come from reflected
// (shift-right) CRC formulations.
// -----------------------------------------------------------------------------
module tb_usb_rx_pkt_decoder;
    logic clk;
    logic rst;

    usb_rx_pkt_decoder_if bus ();

    usb_rx_pkt_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Strobe index: 0 pid_valid, 1 pid_err, 2 token_valid, 3 crc5_err,
    //               4 data_valid, 5 data_done, 6 crc16_err, 7 pkt_err
    int         strobe_cnt [8];
    int         strobe_cyc [8];
    int         both_cnt = 0;
    logic [7:0] dq [$];

    int         base [8];
    int         base_both;
    int         dq_base;
    logic [7:0] pkt [16];
    int         byte_cyc [16];
    int         fall_cyc;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] strobes();
        return {bus.pkt_err, bus.crc16_err, bus.data_done, bus.data_valid,
                bus.crc5_err, bus.token_valid, bus.pid_err, bus.pid_valid};
    endfunction

    always @(negedge clk) begin
        logic [7:0] s;
        s = strobes();
        for (int k = 0; k < 8; k++) begin
            if (s[k]) begin
                strobe_cnt[k] = strobe_cnt[k] + 1;
                strobe_cyc[k] = cyc;
            end
        end
        if (bus.crc16_err && bus.pkt_err) both_cnt = both_cnt + 1;
        if (bus.data_valid) dq.push_back(bus.data_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dlt(input int k);
        return strobe_cnt[k] - base[k];
    endfunction

    function automatic int dlt_all();
        int t;
        t = 0;
        for (int k = 0; k < 8; k++) t += dlt(k);
        return t;
    endfunction

    task automatic snap();
        for (int k = 0; k < 8; k++) base[k] = strobe_cnt[k];
        base_both = both_cnt;
        dq_base   = dq.size();
    endtask

    // USB CRC5 in reflected form over the 11-bit token field.
    function automatic logic [4:0] usb_crc5(input logic [10:0] f);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++)
            c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
        return ~c;
    endfunction

    // USB CRC16 in reflected form over pkt[1..len].
    function automatic logic [15:0] usb_crc16(input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 1; i <= len; i++) begin
            c = c ^ {8'h00, pkt[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic mk_token(input logic [7:0] p, input logic [10:0] f);
        logic [4:0] c;
        c      = usb_crc5(f);
        pkt[0] = p;
        pkt[1] = f[7:0];
        pkt[2] = {c, f[10:8]};
    endtask

    task automatic mk_data_crc(input int len);
        logic [15:0] c;
        c            = usb_crc16(len);
        pkt[len + 1] = c[7:0];
        pkt[len + 2] = c[15:8];
    endtask

    task automatic drive(input logic act, input logic vld, input logic err, input logic [7:0] d);
        @(negedge clk);
        bus.rx_active = act;
        bus.rx_valid  = vld;
        bus.rx_err    = err;
        bus.rx_data   = d;
    endtask

    // Sends pkt[0..n-1]. err_at >= 0 inserts an rx_err cycle before that byte;
    // merge drops rx_active in the same cycle as the last byte.
    task automatic send_pkt(input int n, input int err_at, input bit merge);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            if (i == err_at) drive(1'b1, 1'b0, 1'b1, 8'h00);
            drive(!(merge && i == n - 1), 1'b1, 1'b0, pkt[i]);
            byte_cyc[i] = cyc;
        end
        if (merge) fall_cyc = byte_cyc[n - 1];
        else begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            fall_cyc = cyc;
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst           = 1'b0;
        bus.rx_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_err    = 1'b0;
        bus.rx_data   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_strobes", strobes(), 8'h00);
        check("reset_pid", bus.pid, 4'h0);
        check("reset_fields", {bus.token_addr, bus.token_ep, bus.frame_no, bus.data_out}, 32'h0);
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00);

        // SETUP addr 0 ep 0
        pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10;
        snap(); send_pkt(3, -1, 1'b0);
        check("setup_pid_valid", dlt(0), 1);
        check("setup_pid", bus.pid, 4'hD);
        check("setup_token_valid", dlt(2), 1);
        check("setup_token_latency", strobe_cyc[2], byte_cyc[2] + 1);
        check("setup_no_crc5_err", dlt(3), 0);
        check("setup_addr_ep", {bus.token_addr, bus.token_ep}, {7'h00, 4'h0});

        // IN addr 0x3A ep 5, rx_active falls with the last byte
        mk_token(8'h69, {4'h5, 7'h3A});
        snap(); send_pkt(3, -1, 1'b1);
        check("in_token_valid", dlt(2), 1);
        check("in_no_pkt_err", dlt(7), 0);
        check("in_addr", bus.token_addr, 7'h3A);
        check("in_ep", bus.token_ep, 4'h5);

        // SETUP with corrupted last byte: fields must hold
        pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h11;
        snap(); send_pkt(3, -1, 1'b0);
        check("bad_crc5_err", dlt(3), 1);
        check("bad_no_token_valid", dlt(2), 0);
        check("bad_fields_held", {bus.token_addr, bus.token_ep}, {7'h3A, 4'h5});

        // SOF frame 0x5A3
        mk_token(8'hA5, 11'h5A3);
        snap(); send_pkt(3, -1, 1'b0);
        check("sof_token_valid", dlt(2), 1);
        check("sof_frame_no", bus.frame_no, 11'h5A3);
        check("sof_addr_held", bus.token_addr, 7'h3A);

        // DATA0 zero length
        pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt[2] = 8'h00;
        snap(); send_pkt(3, -1, 1'b0);
        check("zlp0_done", dlt(5), 1);
        check("zlp0_done_latency", strobe_cyc[5], fall_cyc + 1);
        check("zlp0_no_data", dlt(4), 0);
        check("zlp0_no_crc16_err", dlt(6), 0);

        // DATA1 zero length
        pkt[0] = 8'h4B;
        snap(); send_pkt(3, -1, 1'b0);
        check("zlp1_done", dlt(5), 1);
        check("zlp1_no_data", dlt(4), 0);

        // DATA0 AA 55 with bad CRC
        pkt[0] = 8'hC3; pkt[1] = 8'hAA; pkt[2] = 8'h55; pkt[3] = 8'h00; pkt[4] = 8'h00;
        snap(); send_pkt(5, -1, 1'b0);
        check("badcrc_data_count", dlt(4), 2);
        check("badcrc_byte0", dq[dq_base], 8'hAA);
        check("badcrc_byte1", dq[dq_base + 1], 8'h55);
        check("badcrc_crc16_err", dlt(6), 1);
        check("badcrc_no_done", dlt(5), 0);

        // DATA0 01 02 03 04 with good CRC
        pkt[0] = 8'hC3; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03; pkt[4] = 8'h04;
        mk_data_crc(4);
        snap(); send_pkt(7, -1, 1'b0);
        check("good_data_count", dlt(4), 4);
        check("good_bytes", {dq[dq_base], dq[dq_base + 1], dq[dq_base + 2], dq[dq_base + 3]}, 32'h01020304);
        check("good_last_byte_latency", strobe_cyc[4], byte_cyc[6] + 1);
        check("good_done", dlt(5), 1);
        check("good_no_crc16_err", dlt(6), 0);

        // Short data packet: one byte after the PID
        pkt[0] = 8'hC3; pkt[1] = 8'h00;
        snap(); send_pkt(2, -1, 1'b0);
        check("short_crc16_pkt_err_together", both_cnt - base_both, 1);
        check("short_pkt_err", dlt(7), 1);
        check("short_no_done", dlt(5), 0);

        // PID nibble mismatch, trailing bytes ignored
        pkt[0] = 8'h2C; pkt[1] = 8'h00; pkt[2] = 8'h10;
        snap(); send_pkt(3, -1, 1'b0);
        check("badpid_pid_err", dlt(1), 1);
        check("badpid_no_other_strobes", dlt_all() - dlt(1), 0);

        // ACK followed by an extra byte
        pkt[0] = 8'hD2; pkt[1] = 8'h00;
        snap(); send_pkt(2, -1, 1'b0);
        check("ack_pid_valid", dlt(0), 1);
        check("ack_pid", bus.pid, 4'h2);
        check("ack_extra_pkt_err", dlt(7), 1);

        // rx_err after the first token byte
        pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10;
        snap(); send_pkt(3, 2, 1'b0);
        check("rxerr_pkt_err", dlt(7), 1);
        check("rxerr_no_token_strobes", dlt(2) + dlt(3), 0);

        // Async reset in the middle of a data packet
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'hC3);
        drive(1'b1, 1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b1, 1'b0, 8'h33);
        drive(1'b1, 1'b1, 1'b0, 8'h44);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_strobes", strobes(), 8'h00);
        check("arst_pid", bus.pid, 4'h0);
        check("arst_fields", {bus.token_addr, bus.token_ep, bus.frame_no, bus.data_out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        snap();
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b1, 1'b0, 8'h66);
        drive(1'b1, 1'b1, 1'b0, 8'h77);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("arst_tail_ignored", dlt_all(), 0);

        pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10;
        snap(); send_pkt(3, -1, 1'b0);
        check("after_arst_pid", bus.pid, 4'hD);
        check("after_arst_token_valid", dlt(2), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/usb_rx_pkt_decoder.md
Name: usb_rx_pkt_decoder

Overview:
Packet disassembler that sits directly downstream of the USB receive PHY. It consumes the UTMI receive byte stream (DataIn/RxValid/RxActive/RxError) and decodes and checks the PID. For token packets it extracts address and endpoint and checks CRC5. For data packets it strips the two CRC bytes before forwarding the payload, and checks CRC16. All results go to the protocol engine as single-cycle strobes plus held fields.

Parameters:
None.

Ports:
clk  in  1  48 MHz system clock (same clock as receive PHY)
rst  in  1  asynchronous active-low reset
rx_data  in  8  UTMI DataIn, valid when rx_valid=1
rx_valid  in  1  byte strobe, one clk per byte
rx_active  in  1  packet in progress; falls after EOP
rx_err  in  1  PHY error (sync, bit-stuff or byte error)
pid  out  4  last decoded PID[3:0], held until next packet
pid_valid  out  1  1-clk pulse, PID byte accepted and check passed
pid_err  out  1  1-clk pulse, PID[7:4] != ~PID[3:0]
token_addr  out  7  token address, held
token_ep  out  4  token endpoint, held
token_valid  out  1  1-clk pulse, token complete with CRC5 good
crc5_err  out  1  1-clk pulse, token complete with CRC5 bad
frame_no  out  11  SOF frame number, held; updated with token_valid on SOF PID (4'h5)
data_out  out  8  payload byte
data_valid  out  1  1-clk pulse per payload byte (CRC bytes never presented)
data_done  out  1  1-clk pulse at end of data packet with CRC16 good
crc16_err  out  1  1-clk pulse at end of data packet with CRC16 bad
pkt_err  out  1  1-clk pulse, malformed packet (wrong length, rx_err)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC registers at their init values.
- FSM states: IDLE, PID, TOKEN, DATA, HSHK, DRAIN.
- IDLE -> PID on rx_active=1.
- PID: first rx_valid byte is the PID.
  - Check fails: pid_err pulse, -> DRAIN.
  - Check passes: latch pid, pulse pid_valid.
  - PID[1:0]=01 (token incl. SOF) -> TOKEN; PID[1:0]=11 (data) -> DATA; PID[1:0]=10 (handshake) -> HSHK; PID[1:0]=00 (special) -> DRAIN.
- TOKEN:
  - Accepts exactly 2 bytes. Byte0 = {addr[6:0] in bits 6:0, ep[0] in bit 7}. Byte1 = {crc5 in bits 7:3, ep[3:1] in bits 2:0}.
  - On 2nd byte, next clk: token_valid or crc5_err pulse; addr/ep (or frame_no for SOF) latched only when the CRC is good.
  - A third byte -> pkt_err, DRAIN.
  - rx_active falls with fewer than 2 bytes -> pkt_err, IDLE.
- CRC5: polynomial x^5+x^2+1, init 5'h1F, bits fed LSB first over all 16 bits after the PID. Good iff residual == 5'h0C.
- DATA:
  - Two-byte delay line. Byte n is emitted on data_out with data_valid one clk after byte n+2 arrives. The final two bytes (CRC16) are never emitted.
  - CRC16: polynomial x^16+x^15+x^2+1, init 16'hFFFF, LSB first over all bytes after the PID including the CRC bytes. Good iff residual == 16'h800D.
  - On rx_active falling edge: data_done or crc16_err pulse, exactly 1 clk later.
  - Fewer than 2 bytes after the PID: crc16_err and pkt_err pulse together.
  - Zero-length packet (exactly 2 CRC bytes): data_done with no data_valid.
- HSHK: any byte after the PID -> pkt_err, DRAIN.
- DRAIN: ignore bytes until rx_active=0, then IDLE.
- rx_err=1 in any non-IDLE state:
  - pkt_err pulse, -> DRAIN.
  - Suppress any pending token_valid/data_done/crc strobes.
  - Bytes already emitted stand.
- rx_active falling and rx_valid in the same clk: the byte is processed first, then the end of packet.
- A new rx_active rise is ignored until the FSM has returned to IDLE. At most 1 clk of end processing.
- Async reset mid-packet: immediate return to reset state. Subsequent bytes ignored until the next rx_active rising edge.
- Outputs registered; strobes are mutually exclusive except crc16_err+pkt_err on a short data packet.

Test Plan:
- SETUP token bytes 2D 00 10 -> pid_valid with pid=4'hD; token_valid 1 clk after 3rd byte; token_addr=0, token_ep=0; no crc5_err.
- Same token with last byte 11 -> crc5_err pulse, no token_valid, token_addr/ep keep previous values.
- DATA0 zero-length C3 00 00 then rx_active fall -> data_done pulse, zero data_valid pulses. DATA1 4B 00 00 -> same result.
- DATA0 C3 AA 55 00 00 with bad CRC -> data_valid for AA and 55 only, then crc16_err, no data_done.
- PID byte 2C (nibble mismatch) -> pid_err, no further strobes until the next packet. ACK D2 followed by an extra byte -> pkt_err.
- rx_err asserted after the 1st token byte -> pkt_err, no token_valid/crc5_err. Async reset mid-DATA -> all outputs 0 immediately; the next clean packet decodes correctly.
